// File: rtl/seq_divider.sv
// seq_divider: unsigned restoring divider, one quotient bit per clock, MSB first.
module seq_divider #(
  parameter int WIDTH_N = 16,
  parameter int WIDTH_D = 8,
  parameter int CNT_W   = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH_N-1:0] in_N,
  input  logic [WIDTH_D-1:0] in_D,
  output logic [WIDTH_N-1:0] quot,
  output logic [WIDTH_D-1:0] rem,
  output logic               busy,
  output logic               done,
  output logic               div_zero
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH_D-1:0] pr, pr_nx, d;
  logic [WIDTH_D:0] pr_sh;
  logic [WIDTH_N-1:0] n, q, q_nx;
  logic ge, last;
  assign busy = state != IDLE;
  assign done = state == DONE;
  always_comb begin
    pr_sh = {pr, n[WIDTH_N-1]};
    ge = pr_sh >= {1'b0, d};
    pr_nx = ge ? WIDTH_D'(pr_sh - {1'b0, d}) : pr_sh[WIDTH_D-1:0];
    q_nx = {q[WIDTH_N-2:0], ge};
    // a zero divisor finishes after a single CALC cycle
    last = d == '0 || cnt == CNT_W'(WIDTH_N - 1);
    state_nx = state;
    unique case (state)
      IDLE: state_nx = start ? CALC : IDLE;
      CALC: state_nx = last ? DONE : CALC;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      pr <= '0;
      n <= '0;
      d <= '0;
      q <= '0;
      quot <= '0;
      rem <= '0;
      div_zero <= 1'b0;
    end else begin
      state <= state_nx;
      unique case (state)
        IDLE: if (start) begin
          n <= in_N;
          d <= in_D;
          pr <= '0;
          q <= '0;
          cnt <= '0;
        end
        CALC: begin
          n <= n << 1;
          pr <= pr_nx;
          q <= q_nx;
          cnt <= cnt + CNT_W'(1);
          if (d == '0) begin
            quot <= '1;
            rem <= d;
            div_zero <= 1'b1;
          end else if (last) begin
            quot <= q_nx;
            rem <= pr_nx;
            div_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
